fetch_line_fill_memory: RTL and testbench

//  Backing instruction memory directly upstream of the fetch I-cache: it supplies 128-bit lines on a miss.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_line_fill_memory_if.sv | 26 ++
 rtl/fetch_line_fill_memory_line_store.sv | 26 ++
 rtl/fetch_line_fill_memory.sv | 99 +++++++++
 tb/tb_fetch_line_fill_memory.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Types and constants shared between the line-fill memory and the fetch I-cache.
package fetch_pkg;

    localparam int LINE_W   = 128;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 2;
    localparam int ADDR_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } fill_req_t;

    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [ADDR_W-1:0] addr;
    } fill_resp_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~(ADDR_W'((1 << OFFSET_W) - 1));
    endfunction

endpackage

// File: rtl/fetch_line_fill_memory_if.sv
// Line-fill bus between the fetch I-cache (master) and the backing memory (slave).
// Handshake: a request transfers when req_valid && req_ready at a rising edge; a response
// transfers when resp_valid && resp_ready; req_abort overrides both and drops any fill.
interface fetch_line_fill_memory_if;
    import fetch_pkg::*;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              req_abort;
    logic              resp_valid;
    logic              resp_ready;
    logic [LINE_W-1:0] resp_line;
    logic [ADDR_W-1:0] resp_addr;

    modport master (
        output req_valid, req_addr, req_abort, resp_ready,
        input  req_ready, resp_valid, resp_line, resp_addr
    );

    modport slave (
        input  req_valid, req_addr, req_abort, resp_ready,
        output req_ready, resp_valid, resp_line, resp_addr
    );

endinterface

// File: rtl/fetch_line_fill_memory_line_store.sv
// Line storage: synchronous preload write port, asynchronous read port. Contents are never reset.
module line_store
    import fetch_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/fetch_line_fill_memory.sv
// Backing instruction memory for the I-cache: accepts one line fill, waits LATENCY cycles,
// then holds the line and its aligned address until the cache consumes it.
module fetch_line_fill_memory
    import fetch_pkg::*;
#(
    parameter int LATENCY     = 8,
    parameter int DEPTH_LINES = 64,
    localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_line_fill_memory_if.slave bus,
    input  logic                   ld_en,
    input  logic [IDX_W-1:0]       ld_idx,
    input  logic [LINE_W-1:0]      ld_line,
    output logic                   busy,
    output logic [15:0]            fill_count,
    output state_e                 state_o
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    fill_resp_t        resp_q, resp_d;
    logic [15:0]       fill_count_q, fill_count_d;
    logic [LINE_W-1:0] rd_line;
    logic              accept;

    line_store #(.DEPTH_LINES(DEPTH_LINES)) u_store (
        .clk     (clk),
        .we_i    (ld_en),
        .widx_i  (ld_idx),
        .wdata_i (ld_line),
        .ridx_i  (bus.req_addr[OFFSET_W +: IDX_W]),
        .rdata_o (rd_line)
    );

    assign bus.req_ready = (state_q == IDLE) && !bus.req_abort;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        fill_count_d = fill_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // The read is combinational, so a preload on the same edge is not yet visible.
                    resp_d.line = rd_line;
                    resp_d.addr = line_align(bus.req_addr);
                    cnt_d       = 4'(LATENCY - 1);
                    state_d     = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (bus.req_abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.req_abort) begin
                    state_d = IDLE;
                end else if (bus.resp_ready) begin
                    state_d = IDLE;
                    if (fill_count_q != 16'hFFFF) begin
                        fill_count_d = fill_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_q       <= '0;
            fill_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
            fill_count_q <= fill_count_d;
        end
    end

    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_line  = resp_q.line;
    assign bus.resp_addr  = resp_q.addr;
    assign busy           = (state_q != IDLE);
    assign fill_count     = fill_count_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_fetch_line_fill_memory.sv
// Directed bench for the line-fill memory: an 8-cycle instance and a 1-cycle instance.
module tb_fetch_line_fill_memory;
    import fetch_pkg::*;

    localparam logic [127:0] L1 = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    localparam logic [127:0] L2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] L3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_line_fill_memory_if bus ();
    fetch_line_fill_memory_if bus2 ();

    logic         ld_en, ld2_en;
    logic [5:0]   ld_idx, ld2_idx;
    logic [127:0] ld_line, ld2_line;
    logic         busy, busy2;
    logic [15:0]  fill_count, fill_count2;
    state_e       state_dbg, state2_dbg;

    fetch_line_fill_memory #(.LATENCY(8), .DEPTH_LINES(64)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_line(ld_line),
        .busy(busy), .fill_count(fill_count), .state_o(state_dbg)
    );

    fetch_line_fill_memory #(.LATENCY(1), .DEPTH_LINES(64)) dut_lat1 (
        .clk(clk), .rst(rst), .bus(bus2.slave),
        .ld_en(ld2_en), .ld_idx(ld2_idx), .ld_line(ld2_line),
        .busy(busy2), .fill_count(fill_count2), .state_o(state2_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [127:0] line);
        ld_en = 1'b1; ld_idx = idx; ld_line = line;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic request(input logic [31:0] addr);
        bus.req_valid = 1'b1; bus.req_addr = addr;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Returns cycles from accept until resp_valid, bounded at 30.
    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!bus.resp_valid && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    int cyc;
    logic [127:0] exp_line;
    logic [127:0] held_line;

    initial begin
        bus.req_valid = 0; bus.req_addr = '0; bus.req_abort = 0; bus.resp_ready = 0;
        bus2.req_valid = 0; bus2.req_addr = '0; bus2.req_abort = 0; bus2.resp_ready = 1;
        ld_en = 0; ld_idx = '0; ld_line = '0;
        ld2_en = 0; ld2_idx = '0; ld2_line = '0;
        #1;
        tick(); tick();
        rst = 1'b1;

        check("rst_resp_valid", 128'(bus.resp_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_fill_count", 128'(fill_count), 128'd0);
        check("rst_resp_line", bus.resp_line, 128'd0);
        check("rst_resp_addr", 128'(bus.resp_addr), 128'd0);
        check("rst_req_ready", 128'(bus.req_ready), 128'd1);

        // Test 1: basic fill with 8-cycle latency
        preload(6'd5, L1);
        preload(6'd9, L2);
        request(32'h0000_0016);
        check("t1_busy_after_accept", 128'(busy), 128'd1);
        check("t1_req_ready_busy", 128'(bus.req_ready), 128'd0);
        wait_resp(cyc);
        check("t1_latency", 128'(cyc), 128'd8);
        check("t1_resp_line", bus.resp_line, L1);
        check("t1_resp_addr", 128'(bus.resp_addr), 128'h0000_0014);

        // Test 2: response holds under back-pressure
        held_line = bus.resp_line;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 128'(bus.resp_valid), 128'd1);
            check("t2_hold_line", bus.resp_line, held_line);
            check("t2_hold_req_ready", 128'(bus.req_ready), 128'd0);
        end
        check("t2_count_before", 128'(fill_count), 128'd0);
        consume();
        check("t2_idle_state", 128'(state_dbg), 128'(IDLE));
        check("t2_resp_valid_low", 128'(bus.resp_valid), 128'd0);
        check("t2_fill_count", 128'(fill_count), 128'd1);

        // Test 3: abort mid-wait, then a fresh request right after
        request(32'h0000_0024);
        tick(); tick();
        bus.req_abort = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0024;
        check("t3_req_ready_abort", 128'(bus.req_ready), 128'd0);
        tick();
        bus.req_abort = 1'b0; bus.req_valid = 1'b0;
        check("t3_busy_after_abort", 128'(busy), 128'd0);
        check("t3_resp_valid_after_abort", 128'(bus.resp_valid), 128'd0);
        check("t3_count_after_abort", 128'(fill_count), 128'd1);
        request(32'h0000_0027);
        wait_resp(cyc);
        check("t3_latency", 128'(cyc), 128'd8);
        check("t3_resp_line", bus.resp_line, L2);
        check("t3_resp_addr", 128'(bus.resp_addr), 128'h0000_0024);
        consume();
        check("t3_fill_count", 128'(fill_count), 128'd2);

        // Abort during RESP together with resp_ready: dropped, not counted
        request(32'h0000_0014);
        wait_resp(cyc);
        bus.req_abort = 1'b1; bus.resp_ready = 1'b1;
        tick();
        bus.req_abort = 1'b0; bus.resp_ready = 1'b0;
        check("t3_resp_abort_valid", 128'(bus.resp_valid), 128'd0);
        check("t3_resp_abort_count", 128'(fill_count), 128'd2);

        // Test 4: same-cycle preload and accept returns the old line
        ld_en = 1'b1; ld_idx = 6'd5; ld_line = L3;
        request(32'h0000_0014);
        ld_en = 1'b0;
        wait_resp(cyc);
        check("t4_old_line", bus.resp_line, L1);
        consume();
        check("t4_fill_count_a", 128'(fill_count), 128'd3);
        request(32'h0000_1017);
        wait_resp(cyc);
        check("t4_new_line_aliased", bus.resp_line, L3);
        check("t4_full_addr", 128'(bus.resp_addr), 128'h0000_1014);
        consume();
        check("t4_fill_count_b", 128'(fill_count), 128'd4);

        // Test 5: reset in the middle of a wait
        request(32'h0000_0016);
        tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_resp_valid", 128'(bus.resp_valid), 128'd0);
        check("t5_busy", 128'(busy), 128'd0);
        check("t5_fill_count", 128'(fill_count), 128'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_no_late_resp", 128'(bus.resp_valid), 128'd0);
        end
        request(32'h0000_0016);
        wait_resp(cyc);
        check("t5_latency", 128'(cyc), 128'd8);
        check("t5_mem_retained", bus.resp_line, L3);
        consume();
        check("t5_fill_count_after", 128'(fill_count), 128'd1);

        // Test 6: LATENCY=1 instance, resp_ready tied high, one response every 2 cycles
        for (int i = 0; i < 3; i++) begin
            ld2_en = 1'b1; ld2_idx = 6'(i); ld2_line = {4{32'hC0DE_0000 + 32'(i)}};
            tick();
        end
        ld2_en = 1'b0;
        check("t6_count_start", 128'(fill_count2), 128'd0);
        bus2.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus2.req_addr = 32'(i * 4 + 1);
            tick();
            exp_line = {4{32'hC0DE_0000 + 32'(i)}};
            check("t6_resp_valid", 128'(bus2.resp_valid), 128'd1);
            check("t6_resp_line", bus2.resp_line, exp_line);
            check("t6_resp_addr", 128'(bus2.resp_addr), 128'(i * 4));
            tick();
            check("t6_idle_after", 128'(busy2), 128'd0);
            check("t6_fill_count", 128'(fill_count2), 128'(i + 1));
        end
        bus2.req_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
